// File: rtl/mmio_bridge.sv
// rtl/mmio_bridge.sv - data-side address decoder, write demux and read-return mux for DM/Timer0/Timer1
module mmio_bridge #(
    parameter logic [31:0] DM_BASE = 32'h0000_0000,
    parameter logic [31:0] DM_TOP  = 32'h0000_2FFF,
    parameter logic [31:0] T0_BASE = 32'h0000_7F00,
    parameter logic [31:0] T1_BASE = 32'h0000_7F10,
    parameter int          IRQ_W   = 6
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [31:0]      i_cpu_addr,
    input  logic [31:0]      i_cpu_wdata,
    input  logic [3:0]       i_cpu_be,
    input  logic             i_cpu_we,
    input  logic             i_cpu_re,
    output logic [31:0]      o_cpu_rdata,
    output logic             o_bus_err,
    output logic [31:0]      o_bus_err_addr,
    output logic [31:0]      o_dev_addr,
    output logic [31:0]      o_dev_wdata,
    output logic [3:0]       o_dm_we,
    output logic             o_t0_we,
    output logic             o_t1_we,
    input  logic [31:0]      i_dm_rdata,
    input  logic [31:0]      i_t0_rdata,
    input  logic [31:0]      i_t1_rdata,
    input  logic [IRQ_W-1:0] i_irq_in,
    output logic [IRQ_W-1:0] o_hwint
);

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_DM   = 2'd1,
        SEL_T0   = 2'd2,
        SEL_T1   = 2'd3
    } sel_e;

    sel_e             w_region;
    sel_e             r_rd_sel;
    logic             w_hit_dm;
    logic             w_word_ok;
    logic             w_hit_t0;
    logic             w_hit_t1;
    logic             w_legal;
    logic             w_err;
    logic             w_wr_ok;
    logic             r_bus_err;
    logic [31:0]      r_bus_err_addr;
    logic [IRQ_W-1:0] r_hwint;

    // Offset form keeps the range check a single unsigned compare even when DM_BASE is 0.
    assign w_hit_dm  = (i_cpu_addr - DM_BASE) <= (DM_TOP - DM_BASE);
    assign w_word_ok = (i_cpu_addr[3:2] != 2'b11) && (i_cpu_addr[1:0] == 2'b00);
    assign w_hit_t0  = (i_cpu_addr[31:4] == T0_BASE[31:4]) && w_word_ok;
    assign w_hit_t1  = (i_cpu_addr[31:4] == T1_BASE[31:4]) && w_word_ok;

    always_comb begin
        w_region = SEL_NONE;
        if (w_hit_dm)
            w_region = SEL_DM;
        else if (w_hit_t0)
            w_region = SEL_T0;
        else if (w_hit_t1)
            w_region = SEL_T1;
    end

    // Timers take full words only; offset 0x8 is the read-only count register.
    always_comb begin
        w_legal = 1'b0;
        case (w_region)
            SEL_DM:         w_legal = 1'b1;
            SEL_T0, SEL_T1: w_legal = (i_cpu_be == 4'hF) &&
                                      !(i_cpu_we && (i_cpu_addr[3:2] == 2'b10));
            default:        w_legal = 1'b0;
        endcase
    end

    assign w_err   = (i_cpu_we || i_cpu_re) && !w_legal;
    assign w_wr_ok = i_cpu_we && w_legal;

    assign o_dev_addr  = i_cpu_addr;
    assign o_dev_wdata = i_cpu_wdata;
    assign o_dm_we     = (w_wr_ok && (w_region == SEL_DM)) ? i_cpu_be : 4'b0000;
    assign o_t0_we     = w_wr_ok && (w_region == SEL_T0);
    assign o_t1_we     = w_wr_ok && (w_region == SEL_T1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_sel       <= SEL_NONE;
            r_bus_err      <= 1'b0;
            r_bus_err_addr <= 32'h0;
            r_hwint        <= '0;
        end else begin
            // A write wins over a simultaneous read, so only a pure legal read selects a slave.
            r_rd_sel  <= (i_cpu_re && !i_cpu_we && w_legal) ? w_region : SEL_NONE;
            r_bus_err <= w_err;
            if (w_err)
                r_bus_err_addr <= i_cpu_addr;
            r_hwint <= i_irq_in;
        end
    end

    always_comb begin
        o_cpu_rdata = 32'h0;
        case (r_rd_sel)
            SEL_DM:  o_cpu_rdata = i_dm_rdata;
            SEL_T0:  o_cpu_rdata = i_t0_rdata;
            SEL_T1:  o_cpu_rdata = i_t1_rdata;
            default: o_cpu_rdata = 32'h0;
        endcase
    end

    assign o_bus_err      = r_bus_err;
    assign o_bus_err_addr = r_bus_err_addr;
    assign o_hwint        = r_hwint;

endmodule

// File: tb/tb_mmio_bridge.sv
// tb/tb_mmio_bridge.sv - directed and randomized checks of mmio_bridge against a region/legality model
module tb_mmio_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] cpu_addr = 32'h0;
    logic [31:0] cpu_wdata = 32'h0;
    logic [3:0]  cpu_be = 4'h0;
    logic        cpu_we = 1'b0;
    logic        cpu_re = 1'b0;
    logic [31:0] cpu_rdata;
    logic        bus_err;
    logic [31:0] bus_err_addr;
    logic [31:0] dev_addr;
    logic [31:0] dev_wdata;
    logic [3:0]  dm_we;
    logic        t0_we;
    logic        t1_we;
    logic [31:0] dm_rdata = 32'h0;
    logic [31:0] t0_rdata = 32'h0;
    logic [31:0] t1_rdata = 32'h0;
    logic [5:0]  irq_in = 6'h0;
    logic [5:0]  hwint;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Reference state: what the previous cycle's request should produce now.
    int          m_sel = 0;
    bit          m_err = 1'b0;
    logic [31:0] m_err_addr = 32'h0;
    logic [5:0]  m_irq = 6'h0;

    mmio_bridge dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_cpu_addr     (cpu_addr),
        .i_cpu_wdata    (cpu_wdata),
        .i_cpu_be       (cpu_be),
        .i_cpu_we       (cpu_we),
        .i_cpu_re       (cpu_re),
        .o_cpu_rdata    (cpu_rdata),
        .o_bus_err      (bus_err),
        .o_bus_err_addr (bus_err_addr),
        .o_dev_addr     (dev_addr),
        .o_dev_wdata    (dev_wdata),
        .o_dm_we        (dm_we),
        .o_t0_we        (t0_we),
        .o_t1_we        (t1_we),
        .i_dm_rdata     (dm_rdata),
        .i_t0_rdata     (t0_rdata),
        .i_t1_rdata     (t1_rdata),
        .i_irq_in       (irq_in),
        .o_hwint        (hwint)
    );

    always #5 clk = ~clk;

    // 0 = unmapped, 1 = DM, 2 = Timer0, 3 = Timer1
    function automatic int exp_region(input logic [31:0] a);
        if (a <= 32'h0000_2FFF) return 1;
        if (a >= 32'h0000_7F00 && a <= 32'h0000_7F0B && (a % 4) == 0) return 2;
        if (a >= 32'h0000_7F10 && a <= 32'h0000_7F1B && (a % 4) == 0) return 3;
        return 0;
    endfunction

    function automatic bit exp_legal(input logic [31:0] a, input logic [3:0] be, input logic we);
        int r = exp_region(a);
        if (r == 1) return 1'b1;
        if (r == 0) return 1'b0;
        if (be != 4'hF) return 1'b0;
        if (we && (a % 16) == 8) return 1'b0;
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [31:0] a, input logic [3:0] be, input logic we,
                          input logic re, input logic [5:0] irq);
        cpu_addr  = a;
        cpu_wdata = $urandom;
        cpu_be    = be;
        cpu_we    = we;
        cpu_re    = re;
        irq_in    = irq;
        dm_rdata  = $urandom;
        t0_rdata  = $urandom;
        t1_rdata  = $urandom;
    endtask

    task automatic check_now();
        int          r;
        bit          ok;
        logic [31:0] exp_rd;
        #1;
        r  = exp_region(cpu_addr);
        ok = exp_legal(cpu_addr, cpu_be, cpu_we);
        chk("dm_we", {28'h0, dm_we}, (cpu_we && ok && r == 1) ? {28'h0, cpu_be} : 32'h0);
        chk("t0_we", {31'h0, t0_we}, {31'h0, cpu_we && ok && r == 2});
        chk("t1_we", {31'h0, t1_we}, {31'h0, cpu_we && ok && r == 3});
        chk("dev_addr", dev_addr, cpu_addr);
        chk("dev_wdata", dev_wdata, cpu_wdata);
        exp_rd = (m_sel == 1) ? dm_rdata : (m_sel == 2) ? t0_rdata : (m_sel == 3) ? t1_rdata : 32'h0;
        chk("cpu_rdata", cpu_rdata, exp_rd);
        chk("bus_err", {31'h0, bus_err}, {31'h0, m_err});
        chk("bus_err_addr", bus_err_addr, m_err_addr);
        chk("hwint", {26'h0, hwint}, {26'h0, m_irq});
    endtask

    task automatic tick();
        bit ok = exp_legal(cpu_addr, cpu_be, cpu_we);
        m_sel = (cpu_re && !cpu_we && ok) ? exp_region(cpu_addr) : 0;
        m_err = (cpu_we || cpu_re) && !ok;
        if (m_err) m_err_addr = cpu_addr;
        m_irq = irq_in;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        set_in(32'h0, 4'h0, 1'b0, 1'b0, 6'h0);
        check_now();
        tick();
    endtask

    initial begin
        logic [31:0] a;
        logic [3:0]  be;

        // Reset state, held while inputs (including irq) are active
        set_in(32'h0000_0010, 4'hF, 1'b0, 1'b1, 6'h3F);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdata", cpu_rdata, 32'h0);
        chk("rst_bus_err", {31'h0, bus_err}, 32'h0);
        chk("rst_err_addr", bus_err_addr, 32'h0);
        chk("rst_hwint", {26'h0, hwint}, 32'h0);
        set_in(32'h0, 4'h0, 1'b0, 1'b0, 6'h0);
        rst_n = 1'b1;

        // DM byte write
        set_in(32'h0000_0102, 4'b0100, 1'b1, 1'b0, 6'h0);
        check_now();
        chk("dm_byte_we", {28'h0, dm_we}, 32'h4);
        tick();
        idle();
        chk("dm_byte_noerr", {31'h0, bus_err}, 32'h0);

        // Back-to-back reads DM then Timer1
        set_in(32'h0000_0010, 4'hF, 1'b0, 1'b1, 6'h0);
        check_now();
        tick();
        set_in(32'h0000_7F14, 4'hF, 1'b0, 1'b1, 6'h0);
        dm_rdata = 32'hAAAA_0001;
        check_now();
        chk("b2b_dm", cpu_rdata, 32'hAAAA_0001);
        tick();
        set_in(32'h0, 4'h0, 1'b0, 1'b0, 6'h0);
        t1_rdata = 32'h0000_0055;
        check_now();
        chk("b2b_t1", cpu_rdata, 32'h0000_0055);
        tick();

        // Isolated illegal accesses: count-register write, half-word timer write, unmapped read
        for (int i = 0; i < 3; i++) begin
            case (i)
                0:       set_in(32'h0000_7F08, 4'hF,    1'b1, 1'b0, 6'h0);
                1:       set_in(32'h0000_7F04, 4'b0011, 1'b1, 1'b0, 6'h0);
                default: set_in(32'h0000_5000, 4'hF,    1'b0, 1'b1, 6'h0);
            endcase
            a = cpu_addr;
            check_now();
            chk("illegal_no_we", {26'h0, dm_we, t0_we, t1_we}, 32'h0);
            tick();
            set_in(32'h0, 4'h0, 1'b0, 1'b0, 6'h0);
            check_now();
            chk("illegal_err", {31'h0, bus_err}, 32'h1);
            chk("illegal_addr", bus_err_addr, a);
            chk("illegal_rdata", cpu_rdata, 32'h0);
            tick();
            idle();
            chk("illegal_pulse_end", {31'h0, bus_err}, 32'h0);
        end

        // Consecutive illegal reads
        set_in(32'h0000_4000, 4'hF, 1'b0, 1'b1, 6'h0);
        check_now();
        tick();
        set_in(32'h0000_4004, 4'hF, 1'b0, 1'b1, 6'h0);
        check_now();
        chk("b2b_err1", {31'h0, bus_err}, 32'h1);
        chk("b2b_addr1", bus_err_addr, 32'h0000_4000);
        tick();
        set_in(32'h0, 4'h0, 1'b0, 1'b0, 6'h0);
        check_now();
        chk("b2b_err2", {31'h0, bus_err}, 32'h1);
        chk("b2b_addr2", bus_err_addr, 32'h0000_4004);
        tick();
        idle();
        chk("b2b_err_end", {31'h0, bus_err}, 32'h0);

        // Write and read together: write wins, read returns 0
        set_in(32'h0000_7F00, 4'hF, 1'b1, 1'b1, 6'h0);
        check_now();
        chk("wr_rd_t0_we", {31'h0, t0_we}, 32'h1);
        tick();
        set_in(32'h0, 4'h0, 1'b0, 1'b0, 6'h0);
        t0_rdata = 32'h1234_5678;
        check_now();
        chk("wr_rd_rdata", cpu_rdata, 32'h0);
        tick();

        // Single-cycle interrupt pulse
        set_in(32'h0, 4'h0, 1'b0, 1'b0, 6'b000010);
        check_now();
        tick();
        set_in(32'h0, 4'h0, 1'b0, 1'b0, 6'h0);
        check_now();
        chk("irq_lag", {26'h0, hwint}, 32'h2);
        tick();
        idle();
        chk("irq_gone", {26'h0, hwint}, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0:       a = $urandom_range(0, 32'h2FFF);
                1:       a = 32'h0000_2FF8 + $urandom_range(0, 15);
                2:       a = ($urandom_range(0, 1) ? 32'h0000_7F00 : 32'h0000_7F10) + $urandom_range(0, 15);
                default: a = $urandom;
            endcase
            be = $urandom_range(0, 1) ? 4'hF : 4'($urandom);
            set_in(a, be, 1'($urandom), 1'($urandom), 6'($urandom));
            check_now();
            tick();
        end

        // Reset asserted mid-read, with a pending interrupt and error history
        set_in(32'h0000_5000, 4'hF, 1'b0, 1'b1, 6'h15);
        check_now();
        tick();
        set_in(32'h0000_0020, 4'hF, 1'b0, 1'b1, 6'h15);
        check_now();
        tick();
        set_in(32'h0, 4'h0, 1'b0, 1'b0, 6'h0);
        dm_rdata = 32'hDEAD_BEEF;
        check_now();
        chk("pre_rst_rdata", cpu_rdata, 32'hDEAD_BEEF);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rdata", cpu_rdata, 32'h0);
        chk("mid_rst_hwint", {26'h0, hwint}, 32'h0);
        chk("mid_rst_err", {31'h0, bus_err}, 32'h0);
        chk("mid_rst_err_addr", bus_err_addr, 32'h0);
        m_sel = 0;
        m_err = 1'b0;
        m_err_addr = 32'h0;
        m_irq = 6'h0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle();
        chk("post_rst_rdata", cpu_rdata, 32'h0);
        idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mmio_bridge.md
# mmio_bridge

Data-side address decoder and write demultiplexer between the CPU memory stage and its memory-mapped slaves: data memory (DM), Timer0 and Timer1. It routes one CPU access per cycle to exactly one slave and returns the selected slave's read data one cycle later through a registered select. It flags illegal accesses as a registered bus error for the exception logic, and registers the external interrupt lines into the hardware-interrupt vector consumed by CP0.

## Interface
- DM_BASE, 32'h0000_0000, first DM byte address
- DM_TOP, 32'h0000_2FFF, last DM byte address
- T0_BASE, 32'h0000_7F00, Timer0 base; window is 3 words (0x0, 0x4, 0x8)
- T1_BASE, 32'h0000_7F10, Timer1 base; window is 3 words
- IRQ_W, 6, width of hardware interrupt vector
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- cpu_addr  in  32  byte address from memory stage
- cpu_wdata  in  32  write data
- cpu_be  in  4  byte enables (already aligned by CPU)
- cpu_we  in  1  write request
- cpu_re  in  1  read request
- cpu_rdata  out  32  read data, valid the cycle after the request
- bus_err  out  1  registered one-cycle error pulse
- bus_err_addr  out  32  address of the faulting access, held until the next error
- dev_addr  out  32  cpu_addr passthrough to all slaves
- dev_wdata  out  32  cpu_wdata passthrough
- dm_we  out  4  DM byte write enables
- t0_we, t1_we  out  1 each  timer word write enables
- dm_rdata, t0_rdata, t1_rdata  in  32 each  synchronous slave read data, valid one cycle after the address
- irq_in  in  IRQ_W  raw interrupt sources; bit0 = Timer0, bit1 = Timer1, bit2 = external
- hwint  out  IRQ_W  registered interrupt vector

## Operation
- Decode is combinational on cpu_addr. Exactly one of the regions DM, T0, T1 or NONE is selected.
- A DM hit means DM_BASE ≤ addr ≤ DM_TOP.
- A timer hit means addr[31:4] matches the base, addr[3:2] is 0, 1 or 2, and addr[1:0] is 0.
- Legality rules:
  - DM: any cpu_be pattern is legal.
  - Timer: cpu_be must be 4'b1111, otherwise error.
  - A write to timer offset 0x8 (read-only count register) is an error.
  - Any access to NONE is an error.
- Write (cpu_we=1, legal):
  - DM: dm_we = cpu_be.
  - T0/T1: the matching t*_we = 1.
  - All other enables are 0.
- Illegal write: all enables are 0. No slave state changes.
- Read (cpu_re=1): at the clock edge, rd_sel <= region if legal, else NONE.
- cpu_rdata is a combinational mux on rd_sel: DM → dm_rdata, T0 → t0_rdata, T1 → t1_rdata, NONE → 32'h0.
- Simultaneous cpu_we and cpu_re: the write is performed and the read is ignored (rd_sel <= NONE).
- Neither request asserted: rd_sel <= NONE, all enables are 0.
- Error (illegal read or write): at the next edge bus_err <= 1 and bus_err_addr <= cpu_addr.
- bus_err returns to 0 on the following cycle unless another error occurs. Back-to-back errors keep bus_err high and update bus_err_addr every cycle.
- Interrupts: every cycle hwint <= irq_in. No masking is done here; CP0 masks.

## Timing
- Write enables: 0-cycle latency, combinational from the request. The slave captures the write on the same edge.
- Read data: 1-cycle latency. cpu_rdata for a request in cycle N is valid throughout cycle N+1.
- Reads may issue every cycle. rd_sel is a pipeline register, so reads in consecutive cycles to different slaves return in order without bubbles.
- bus_err and bus_err_addr are valid in cycle N+1 for a faulting access in cycle N.
- hwint lags irq_in by exactly 1 cycle.
- Reset (rst_n low, asynchronous, at any point including mid-read):
  - rd_sel = NONE, so cpu_rdata = 0.
  - bus_err = 0, bus_err_addr = 0, hwint = 0.
  - Combinational enables still follow their inputs; the CPU holds cpu_we = 0 during reset.
- A read in flight when reset asserts is dropped. The first cycle after reset release returns cpu_rdata = 0.

## Test plan
- DM byte write at addr 0x0000_0102, be = 4'b0100 → dm_we = 4'b0100, t0_we = t1_we = 0, bus_err stays 0.
- Back-to-back reads: DM 0x0000_0010 (dm_rdata = 0xAAAA_0001), then T1 0x0000_7F14 (t1_rdata = 0x0000_0055) → cpu_rdata = 0xAAAA_0001 in cycle 2 and 0x0000_0055 in cycle 3.
- Illegal accesses each give bus_err = 1 for one cycle with bus_err_addr = the address, no enables, cpu_rdata = 0:
  - Timer write to count register 0x0000_7F08.
  - Half-word write to 0x0000_7F04 with be = 4'b0011.
  - Read of unmapped 0x0000_5000.
- Two consecutive illegal reads at 0x0000_4000 then 0x0000_4004 → bus_err high for 2 cycles; bus_err_addr = 0x4000 then 0x4004.
- cpu_we and cpu_re both 1 at T0 0x0000_7F00 → t0_we = 1; next cycle cpu_rdata = 0.
- irq_in = 6'b000010 for one cycle → hwint = 6'b000010 exactly one cycle later for one cycle. Asserting rst_n = 0 mid-read forces cpu_rdata = 0 and hwint = 0 immediately.
